// File: rtl/axi3_rect_blit_writer.sv
// axi3_rect_blit_writer: AXI3 write master that fills a framebuffer rectangle
// from a raster-ordered pixel stream. Each line is cut into INCR bursts limited
// by MAX_BURST, the 4 KB page boundary and the end of the line. Up to
// MAX_OUTSTANDING bursts may wait for their write response at once.
// Optional macro BLIT_ERR_CAPTURE_EN adds err/err_addr error-response capture.
module axi3_rect_blit_writer #(
  parameter int DATA_W          = 32,
  parameter int PIXEL_BYTES     = 1,
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [31:0]              cmd_base,
  input  logic [10:0]              cmd_x,
  input  logic [10:0]              cmd_y,
  input  logic [10:0]              cmd_w,
  input  logic [10:0]              cmd_h,
  input  logic [15:0]              cmd_stride,
  input  logic [8*PIXEL_BYTES-1:0] pix_data,
  input  logic                     pix_draw,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              m_axi_awaddr,
  output logic [3:0]               m_axi_awlen,
  output logic [2:0]               m_axi_awsize,
  output logic [1:0]               m_axi_awburst,
  output logic [3:0]               m_axi_awcache,
  output logic                     m_axi_awvalid,
  input  logic                     m_axi_awready,
  output logic [DATA_W-1:0]        m_axi_wdata,
  output logic [DATA_W/8-1:0]      m_axi_wstrb,
  output logic                     m_axi_wlast,
  output logic                     m_axi_wvalid,
  input  logic                     m_axi_wready,
  input  logic [1:0]               m_axi_bresp,
  input  logic                     m_axi_bvalid,
  output logic                     m_axi_bready
`ifdef BLIT_ERR_CAPTURE_EN
  ,
  output logic                     err,
  output logic [31:0]              err_addr
`endif
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LANE_W = $clog2(STRB_W);
  localparam int SIZE   = $clog2(PIXEL_BYTES);
  localparam int OS_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OS_W-1:0]   OS_MAX   = OS_W'(MAX_OUTSTANDING);
  localparam logic [STRB_W-1:0] PIX_STRB = STRB_W'((1 << PIXEL_BYTES) - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DRAIN} state_t;

  state_t            state;
  logic [31:0]       line_addr;
  logic [31:0]       cur_addr;
  logic [10:0]       rem_w;
  logic [10:0]       rem_h;
  logic [10:0]       line_w;
  logic [15:0]       stride;
  logic [OS_W-1:0]   outstanding;
  logic [4:0]        blen;
  logic [4:0]        beat_cnt;
  logic              bready_r;

  logic [12:0]       room;
  logic [12:0]       len;
  logic [31:0]       start_addr;
  logic [LANE_W-1:0] lane;
  logic              cmd_hs;
  logic              aw_hs;
  logic              w_hs;
  logic              b_hs;

  assign start_addr = cmd_base + 32'(cmd_y) * 32'(cmd_stride)
                    + 32'(cmd_x) * 32'(PIXEL_BYTES);
  assign lane   = cur_addr[LANE_W-1:0];
  assign cmd_hs = cmd_valid && cmd_ready;
  assign aw_hs  = m_axi_awvalid && m_axi_awready;
  assign w_hs   = m_axi_wvalid && m_axi_wready;
  // A response with nothing outstanding belongs to no burst of ours.
  assign b_hs   = m_axi_bvalid && m_axi_bready && (outstanding != '0);

  // Burst length: remaining line, burst cap and room left in the 4 KB page.
  always_comb begin
    room = (13'd4096 - {1'b0, cur_addr[11:0]}) >> SIZE;
    len  = {2'b00, rem_w};
    if (len > 13'(MAX_BURST)) len = 13'(MAX_BURST);
    if (len > room)           len = room;
  end

  assign cmd_ready     = (state == S_IDLE);
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DRAIN) && (outstanding == '0);

  // Outstanding only falls while in ADDR, so awvalid never drops before its handshake.
  assign m_axi_awvalid = (state == S_ADDR) && (outstanding < OS_MAX);
  assign m_axi_awaddr  = cur_addr;
  assign m_axi_awlen   = 4'(len - 13'd1);
  assign m_axi_awsize  = 3'(SIZE);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awcache = 4'b0111;

  assign m_axi_wvalid  = (state == S_DATA) && pix_valid;
  assign pix_ready     = (state == S_DATA) && m_axi_wready;
  assign m_axi_wdata   = DATA_W'(pix_data) << {lane, 3'b000};
  assign m_axi_wstrb   = pix_draw ? (PIX_STRB << lane) : '0;
  assign m_axi_wlast   = (state == S_DATA) && (beat_cnt == blen - 5'd1);
  assign m_axi_bready  = bready_r;

  // Command FSM, burst bookkeeping and the outstanding-response counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      outstanding <= '0;
      bready_r    <= 1'b0;
    end else begin
      bready_r <= 1'b1;
      if (aw_hs && !b_hs)      outstanding <= outstanding + OS_W'(1);
      else if (b_hs && !aw_hs) outstanding <= outstanding - OS_W'(1);

      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            line_addr <= start_addr;
            cur_addr  <= start_addr;
            rem_w     <= cmd_w;
            rem_h     <= cmd_h;
            line_w    <= cmd_w;
            stride    <= cmd_stride;
            state     <= (cmd_w == '0 || cmd_h == '0) ? S_DRAIN : S_ADDR;
          end
        end
        S_ADDR: begin
          if (aw_hs) begin
            blen     <= 5'(len);
            beat_cnt <= '0;
            state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_hs) begin
            cur_addr <= cur_addr + 32'(PIXEL_BYTES);
            rem_w    <= rem_w - 11'd1;
            beat_cnt <= beat_cnt + 5'd1;
            if (m_axi_wlast) begin
              if (rem_w != 11'd1) begin
                state <= S_ADDR;
              end else if (rem_h > 11'd1) begin
                rem_h     <= rem_h - 11'd1;
                line_addr <= line_addr + 32'(stride);
                cur_addr  <= line_addr + 32'(stride);
                rem_w     <= line_w;
                state     <= S_ADDR;
              end else begin
                state <= S_DRAIN;
              end
            end
          end
        end
        S_DRAIN: begin
          if (outstanding == '0) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef BLIT_ERR_CAPTURE_EN
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  logic [31:0]      addr_fifo [1 << PTR_W];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // AW address FIFO in response order; the first error response of a command is captured.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      err    <= 1'b0;
    end else begin
      if (aw_hs) begin
        addr_fifo[wr_ptr] <= m_axi_awaddr;
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (b_hs) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      if (cmd_hs) begin
        err <= 1'b0;
      end else if (b_hs && m_axi_bresp[1] && !err) begin
        err      <= 1'b1;
        err_addr <= addr_fifo[rd_ptr];
      end
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^m_axi_bresp ^ cmd_hs;
`endif

endmodule
